hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard beside ID: one countdown per architectural register
// decides each cycle whether the ID instruction issues or IF/ID holds for a bubble.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int WB_DEPTH = 3,
   parameter int FWD_EN   = 1,
   parameter int ALU_LAT  = 0,
   parameter int LOAD_LAT = 1,
   parameter int SW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic [AW-1:0] id_rd,
   input  logic          id_regwr,
   input  logic          id_is_load,
   input  logic          flush,
   input  logic          stat_clr,
   output logic          issue,
   output logic          stall,
   output logic [SW-1:0] stall_count
);

   localparam int CW = (WB_DEPTH < 1) ? 1 : $clog2(WB_DEPTH + 1);

   if (ALU_LAT > WB_DEPTH || LOAD_LAT > WB_DEPTH) begin : g_lat_err
      $error("hazard_scoreboard: ALU_LAT and LOAD_LAT must not exceed WB_DEPTH");
   end
   if (NREG != (1 << AW)) begin : g_nreg_err
      $error("hazard_scoreboard: NREG must equal 2**AW");
   end

   function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
      return (v == '0) ? v : v - CW'(1);
   endfunction

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
      return (&v) ? v : v + SW'(1);
   endfunction

   logic [CW-1:0] cnt     [1:NREG-1];
   logic [CW-1:0] cnt_nxt [1:NREG-1];
   logic [NREG-1:0] busy;
   logic [CW-1:0]   lat;
   logic            hazard;
   logic            wr_en;

   // r0 has no counter, so its busy bit stays zero and never produces a hazard
   always_comb begin
      busy = '0;
      for (int r = 1; r < NREG; r++) begin
         busy[r] = (cnt[r] != '0);
      end
   end

   assign hazard = (id_use_rs && busy[id_rs]) || (id_use_rt && busy[id_rt]);
   assign stall  = id_valid && hazard && !flush;
   assign issue  = id_valid && !hazard && !flush;
   assign wr_en  = issue && id_regwr;

   always_comb begin
      lat = CW'(WB_DEPTH);
      if (FWD_EN != 0) begin
         lat = id_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
      end
   end

   // Longest outstanding latency wins on WAW; a zero latency never raises a counter
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         cnt_nxt[r] = sat_dec(cnt[r]);
         if (wr_en && (id_rd == AW'(r)) && (lat > cnt_nxt[r])) begin
            cnt_nxt[r] = lat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stat_clr) begin
         stall_count <= '0;
      end else if (stall) begin
         stall_count <= sat_inc(stall_count);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: four parameterisations share one stimulus
// stream; expected stall/issue/stall_count values are queued per cycle and checked.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_use_rs, id_use_rt, id_regwr, id_is_load;
   logic       flush, stat_clr;

   logic        st_f, is_f, st_n, is_n, st_w, is_w, st_s, is_s;
   logic [15:0] sc_f, sc_n, sc_w;
   logic [1:0]  sc_s;

   always #5 clk = ~clk;

   // sel 0: forwarding defaults
   hazard_scoreboard u_fwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr),
      .issue(is_f), .stall(st_f), .stall_count(sc_f));

   // sel 1: no forwarding, WB_DEPTH=3
   hazard_scoreboard #(.FWD_EN(0), .WB_DEPTH(3)) u_nofwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr),
      .issue(is_n), .stall(st_n), .stall_count(sc_n));

   // sel 2: long load, short ALU latency to expose the WAW max rule
   hazard_scoreboard #(.FWD_EN(1), .WB_DEPTH(3), .LOAD_LAT(3), .ALU_LAT(1)) u_waw (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr),
      .issue(is_w), .stall(st_w), .stall_count(sc_w));

   // sel 3: 2-bit statistic, 7-cycle writeback for long stalls
   hazard_scoreboard #(.FWD_EN(0), .WB_DEPTH(7), .SW(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .flush(flush), .stat_clr(stat_clr),
      .issue(is_s), .stall(st_s), .stall_count(sc_s));

   typedef struct {
      string tag;
      int    sel;
      logic  st;
      logic  is;
      int    cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic st, input logic is,
                       input int cnt);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.st  = st;
      e.is  = is;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t        e;
      logic        a_st, a_is;
      logic [31:0] a_cnt;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.sel)
            0:       begin a_st = st_f; a_is = is_f; a_cnt = 32'(sc_f); end
            1:       begin a_st = st_n; a_is = is_n; a_cnt = 32'(sc_n); end
            2:       begin a_st = st_w; a_is = is_w; a_cnt = 32'(sc_w); end
            default: begin a_st = st_s; a_is = is_s; a_cnt = 32'(sc_s); end
         endcase
         check_val({e.tag, "_stall"}, 32'(a_st), 32'(e.st));
         check_val({e.tag, "_issue"}, 32'(a_is), 32'(e.is));
         if (e.cnt >= 0) check_val({e.tag, "_count"}, a_cnt, 32'(e.cnt));
      end
   endtask

   task automatic cycle(input string tag, input int sel, input logic st, input logic is,
                        input int cnt);
      push(tag, sel, st, is, cnt);
      @(negedge clk);
      compare_out();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int rs, input logic urs, input int rt,
                        input logic urt, input int rd, input logic wr, input logic ld);
      id_valid   = v;
      id_rs      = 5'(rs);
      id_use_rs  = urs;
      id_rt      = 5'(rt);
      id_use_rt  = urt;
      id_rd      = 5'(rd);
      id_regwr   = wr;
      id_is_load = ld;
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic rst_pulse();
      idle();
      flush    = 1'b0;
      stat_clr = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      stat_clr = 1'b0;
      drive(1'b1, 5, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0);
      #2;
      for (int s = 0; s < 4; s++) push("rst", s, 1'b0, 1'b1, 0);
      compare_out();
      flush = 1'b1;
      #1;
      push("rst_flush", 0, 1'b0, 1'b0, -1);
      compare_out();

      // load-use: one bubble
      rst_pulse();
      drive(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1);
      cycle("lu_lw", 0, 1'b0, 1'b1, 0);
      drive(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0);
      cycle("lu_stall", 0, 1'b1, 1'b0, 0);
      cycle("lu_issue", 0, 1'b0, 1'b1, 1);
      idle();
      cycle("lu_idle", 0, 1'b0, 1'b0, 1);

      // ALU chain: back-to-back with forwarding
      rst_pulse();
      drive(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      cycle("alu_w", 0, 1'b0, 1'b1, 0);
      drive(1'b1, 3, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0);
      cycle("alu_dep", 0, 1'b0, 1'b1, 0);
      idle();
      cycle("alu_idle", 0, 1'b0, 1'b0, 0);

      // no forwarding: three bubbles
      rst_pulse();
      drive(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0);
      cycle("nf_w", 1, 1'b0, 1'b1, 0);
      drive(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0);
      cycle("nf_s1", 1, 1'b1, 1'b0, 0);
      cycle("nf_s2", 1, 1'b1, 1'b0, 1);
      cycle("nf_s3", 1, 1'b1, 1'b0, 2);
      cycle("nf_iss", 1, 1'b0, 1'b1, 3);

      // no forwarding with an independent instruction in between: two bubbles
      rst_pulse();
      drive(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0);
      cycle("gap_w", 1, 1'b0, 1'b1, 0);
      drive(1'b1, 1, 1'b1, 2, 1'b1, 10, 1'b1, 1'b0);
      cycle("gap_ind", 1, 1'b0, 1'b1, 0);
      drive(1'b1, 7, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0);
      cycle("gap_s1", 1, 1'b1, 1'b0, 0);
      cycle("gap_s2", 1, 1'b1, 1'b0, 1);
      cycle("gap_iss", 1, 1'b0, 1'b1, 2);

      // r0 writes never create state, in either mode
      rst_pulse();
      drive(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1);
      cycle("r0_lw", 0, 1'b0, 1'b1, 0);
      drive(1'b1, 0, 1'b1, 0, 1'b1, 1, 1'b1, 1'b0);
      push("r0_use_nf", 1, 1'b0, 1'b1, 0);
      cycle("r0_use", 0, 1'b0, 1'b1, 0);

      // WAW: shorter later writer must not shorten the outstanding load
      rst_pulse();
      drive(1'b1, 1, 1'b1, 0, 1'b0, 9, 1'b1, 1'b1);
      cycle("waw_lw", 2, 1'b0, 1'b1, 0);
      drive(1'b1, 1, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
      push("waw_add_f", 0, 1'b0, 1'b1, 0);
      cycle("waw_add", 2, 1'b0, 1'b1, 0);
      drive(1'b1, 9, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
      cycle("waw_s1", 2, 1'b1, 1'b0, 0);
      cycle("waw_s2", 2, 1'b1, 1'b0, 1);
      cycle("waw_iss", 2, 1'b0, 1'b1, 2);

      // flush mid-stall: counter keeps its schedule
      rst_pulse();
      drive(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0);
      cycle("fl_w", 1, 1'b0, 1'b1, 0);
      drive(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
      cycle("fl_s1", 1, 1'b1, 1'b0, 0);
      flush = 1'b1;
      cycle("fl_fl", 1, 1'b0, 1'b0, 1);
      flush = 1'b0;
      cycle("fl_s3", 1, 1'b1, 1'b0, 1);
      cycle("fl_iss", 1, 1'b0, 1'b1, 2);

      // asynchronous reset mid-stall
      rst_pulse();
      drive(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0);
      cycle("mr_w", 1, 1'b0, 1'b1, 0);
      drive(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
      cycle("mr_s1", 1, 1'b1, 1'b0, 0);
      push("mr_pre", 1, 1'b1, 1'b0, 1);
      compare_out();
      #2;
      rst_n = 1'b0;
      #1;
      push("mr_rst", 1, 1'b0, 1'b1, 0);
      compare_out();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle("mr_after", 1, 1'b0, 1'b1, 0);

      // saturating statistic and clear priority
      rst_pulse();
      drive(1'b1, 1, 1'b1, 3, 1'b1, 2, 1'b1, 1'b0);
      cycle("sat_w", 3, 1'b0, 1'b1, 0);
      drive(1'b1, 2, 1'b1, 0, 1'b0, 11, 1'b1, 1'b0);
      cycle("sat_s1", 3, 1'b1, 1'b0, 0);
      cycle("sat_s2", 3, 1'b1, 1'b0, 1);
      cycle("sat_s3", 3, 1'b1, 1'b0, 2);
      cycle("sat_s4", 3, 1'b1, 1'b0, 3);
      cycle("sat_s5", 3, 1'b1, 1'b0, 3);
      stat_clr = 1'b1;
      cycle("sat_clr", 3, 1'b1, 1'b0, 3);
      stat_clr = 1'b0;
      cycle("sat_s7", 3, 1'b1, 1'b0, 0);
      cycle("sat_iss", 3, 1'b0, 1'b1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
